// File: rtl/mm_arbiter_if.sv
// Bus bundle between the read/write masters, the arbiter and the main-memory RAM ports.
interface mm_arbiter_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_req;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD-1:0]        rd_gnt;
    logic [NUM_RD-1:0]        rd_valid;
    logic [DATA_W-1:0]        rd_data;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic [ADDR_W-1:0]        mem_raddr;
    logic                     mem_wren;
    logic [ADDR_W-1:0]        mem_waddr;
    logic [DATA_W-1:0]        mem_wdata;
    logic [DATA_W-1:0]        mem_rdata;

    // Arbiter side
    modport slave (
        input  rd_req, rd_addr, wr_en, wr_addr, wr_data, mem_rdata,
        output rd_gnt, rd_valid, rd_data, mem_raddr, mem_wren, mem_waddr, mem_wdata
    );

    // Clients plus RAM side
    modport master (
        output rd_req, rd_addr, wr_en, wr_addr, wr_data, mem_rdata,
        input  rd_gnt, rd_valid, rd_data, mem_raddr, mem_wren, mem_waddr, mem_wdata
    );
endinterface

// File: rtl/mm_arbiter.sv
// Main-memory front end: arbitrates NUM_RD read clients onto one RAM read port,
// tags each grant through the RAM latency, and registers the write port straight through.
module mm_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned RAM_LAT  = 1,
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic         clk,
    input  logic         rst,
    mm_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W  = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [IDX_W-1:0]  rr_ptr;
    logic [WAIT_W-1:0] wait_cnt [NUM_RD];
    logic [NUM_RD-1:0] tag_pipe [RAM_LAT];

    logic [ADDR_W-1:0] addr_c [NUM_RD];
    logic [NUM_RD-1:0] starved_c;
    logic              any_req_c;
    logic [IDX_W-1:0]  win_c;
    logic [IDX_W-1:0]  idx_c;
    logic [NUM_RD-1:0] win_oh_c;

    // Unpack client addresses and flag clients that have hit the starvation limit
    always_comb begin
        starved_c = '0;
        for (int i = 0; i < int'(NUM_RD); i++) begin
            addr_c[i]    = bus.rd_addr[i*ADDR_W +: ADDR_W];
            starved_c[i] = (RR_MODE == 0) && (MAX_WAIT != 0) && bus.rd_req[i] &&
                           (wait_cnt[i] == WAIT_W'(MAX_WAIT));
        end
    end

    // Winner selection; in every scan the last hit is the one that sticks
    always_comb begin
        any_req_c = |bus.rd_req;
        win_c     = '0;
        idx_c     = '0;
        if (RR_MODE != 0) begin
            // Scan backwards from ptr+N to ptr+1 so the first requester after ptr wins
            for (int k = int'(NUM_RD); k >= 1; k--) begin
                idx_c = IDX_W'((int'(rr_ptr) + k) % int'(NUM_RD));
                if (bus.rd_req[idx_c]) win_c = idx_c;
            end
        end else if (|starved_c) begin
            for (int i = 0; i < int'(NUM_RD); i++)
                if (starved_c[i]) win_c = IDX_W'(i);
        end else begin
            for (int i = 0; i < int'(NUM_RD); i++)
                if (bus.rd_req[i]) win_c = IDX_W'(i);
        end
        win_oh_c = '0;
        if (any_req_c) win_oh_c[win_c] = 1'b1;
    end

    // Grant, registered RAM read address and round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_gnt    <= '0;
            bus.mem_raddr <= '0;
            rr_ptr        <= IDX_W'(NUM_RD - 1);
        end else begin
            bus.rd_gnt <= win_oh_c;
            if (any_req_c) begin
                bus.mem_raddr <= addr_c[win_c];
                if (RR_MODE != 0) rr_ptr <= win_c;
            end
        end
    end

    // Saturating per-client wait counters for fixed-priority anti-starvation
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_RD); i++) wait_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_RD); i++) begin
                if (!bus.rd_req[i] || win_oh_c[i] || (RR_MODE != 0) || (MAX_WAIT == 0))
                    wait_cnt[i] <= '0;
                else if (wait_cnt[i] != WAIT_W'(MAX_WAIT))
                    wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
            end
        end
    end

    // Grant tags ride alongside the RAM latency; data is captured as the tag emerges
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int d = 0; d < int'(RAM_LAT); d++) tag_pipe[d] <= '0;
            bus.rd_valid <= '0;
            bus.rd_data  <= '0;
        end else begin
            tag_pipe[0] <= bus.rd_gnt;
            for (int d = 1; d < int'(RAM_LAT); d++) tag_pipe[d] <= tag_pipe[d-1];
            bus.rd_valid <= tag_pipe[RAM_LAT-1];
            bus.rd_data  <= DATA_W'(bus.mem_rdata);
        end
    end

    // Write port registered straight through, independent of read arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.mem_wren  <= 1'b0;
            bus.mem_waddr <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_wren  <= bus.wr_en;
            bus.mem_waddr <= ADDR_W'(bus.wr_addr);
            bus.mem_wdata <= DATA_W'(bus.wr_data);
        end
    end
endmodule

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter: fixed-priority, round-robin and long-latency instances.
module tb_mm_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mm_arbiter_if #(.DATA_W(8), .ADDR_W(19), .NUM_RD(2)) if_fix ();
    mm_arbiter_if #(.DATA_W(8), .ADDR_W(19), .NUM_RD(4)) if_rr  ();
    mm_arbiter_if #(.DATA_W(8), .ADDR_W(19), .NUM_RD(2)) if_lat ();

    mm_arbiter #(.DATA_W(8), .ADDR_W(19), .NUM_RD(2), .RAM_LAT(1), .RR_MODE(0), .MAX_WAIT(15))
        u_fix (.clk(clk), .rst(rst), .bus(if_fix));
    mm_arbiter #(.DATA_W(8), .ADDR_W(19), .NUM_RD(4), .RAM_LAT(1), .RR_MODE(1), .MAX_WAIT(15))
        u_rr  (.clk(clk), .rst(rst), .bus(if_rr));
    mm_arbiter #(.DATA_W(8), .ADDR_W(19), .NUM_RD(2), .RAM_LAT(2), .RR_MODE(0), .MAX_WAIT(15))
        u_lat (.clk(clk), .rst(rst), .bus(if_lat));

    // RAM contents as a fixed function of address
    function automatic logic [7:0] mem_val(input logic [18:0] a);
        case (a)
            19'h00042: mem_val = 8'hA5;
            19'h00001: mem_val = 8'h11;
            19'h00002: mem_val = 8'h22;
            19'h00003: mem_val = 8'h33;
            default:   mem_val = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    logic [7:0] lat_r1;
    always @(posedge clk) begin
        if_fix.mem_rdata <= mem_val(if_fix.mem_raddr);
        if_rr.mem_rdata  <= mem_val(if_rr.mem_raddr);
        lat_r1           <= mem_val(if_lat.mem_raddr);
        if_lat.mem_rdata <= lat_r1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_fix.rd_req = '0; if_fix.rd_addr = '0; if_fix.wr_en = 1'b0;
        if_fix.wr_addr = '0; if_fix.wr_data = '0;
        if_rr.rd_req = '0;  if_rr.rd_addr = '0;  if_rr.wr_en = 1'b0;
        if_rr.wr_addr = '0;  if_rr.wr_data = '0;
        if_lat.rd_req = '0; if_lat.rd_addr = '0; if_lat.wr_en = 1'b0;
        if_lat.wr_addr = '0; if_lat.wr_data = '0;
    endtask

    typedef struct {
        logic [1:0]  req;
        logic        we;
        logic [18:0] wa;
        logic [7:0]  wd;
        logic [1:0]  gnt;
        logic [18:0] raddr;
        logic [1:0]  vld;
    } vec_t;

    vec_t tbl [8];
    logic [1:0] b2b_gnt [6];
    logic [1:0] b2b_vld [6];
    logic [7:0] b2b_dat [6];

    initial begin
        // req, we, wa, wd | gnt, raddr, vld   (a0 = 0x00100, a1 = 0x12C00)
        tbl[0] = '{2'b00, 1'b0, 19'h00000, 8'h00, 2'b00, 19'h00000, 2'b00};
        tbl[1] = '{2'b01, 1'b0, 19'h00000, 8'h00, 2'b01, 19'h00100, 2'b00};
        tbl[2] = '{2'b10, 1'b0, 19'h00000, 8'h00, 2'b10, 19'h12C00, 2'b00};
        tbl[3] = '{2'b11, 1'b0, 19'h00000, 8'h00, 2'b10, 19'h12C00, 2'b01};
        tbl[4] = '{2'b00, 1'b1, 19'h00005, 8'h7E, 2'b00, 19'h12C00, 2'b10};
        tbl[5] = '{2'b11, 1'b1, 19'h00006, 8'h3C, 2'b10, 19'h12C00, 2'b10};
        tbl[6] = '{2'b01, 1'b0, 19'h7FFFF, 8'hFF, 2'b01, 19'h00100, 2'b00};
        tbl[7] = '{2'b00, 1'b0, 19'h00000, 8'h00, 2'b00, 19'h00100, 2'b10};

        b2b_gnt = '{2'b01, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00};
        b2b_vld = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b00};
        b2b_dat = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h00};

        idle_inputs();
        rst = 1'b1;
        step(); step();
        chk("rst fix rd_gnt",    32'(if_fix.rd_gnt),    32'h0);
        chk("rst fix rd_valid",  32'(if_fix.rd_valid),  32'h0);
        chk("rst fix rd_data",   32'(if_fix.rd_data),   32'h0);
        chk("rst fix mem_raddr", 32'(if_fix.mem_raddr), 32'h0);
        chk("rst fix mem_wren",  32'(if_fix.mem_wren),  32'h0);
        chk("rst rr rd_gnt",     32'(if_rr.rd_gnt),     32'h0);
        chk("rst lat rd_valid",  32'(if_lat.rd_valid),  32'h0);
        rst = 1'b0;

        // Table: fixed priority with concurrent writes
        if_fix.rd_addr = {19'h12C00, 19'h00100};
        for (int i = 0; i < 8; i++) begin
            if_fix.rd_req  = tbl[i].req;
            if_fix.wr_en   = tbl[i].we;
            if_fix.wr_addr = tbl[i].wa;
            if_fix.wr_data = tbl[i].wd;
            step();
            chk($sformatf("tbl%0d rd_gnt", i),    32'(if_fix.rd_gnt),    32'(tbl[i].gnt));
            chk($sformatf("tbl%0d mem_raddr", i), 32'(if_fix.mem_raddr), 32'(tbl[i].raddr));
            chk($sformatf("tbl%0d rd_valid", i),  32'(if_fix.rd_valid),  32'(tbl[i].vld));
            chk($sformatf("tbl%0d mem_wren", i),  32'(if_fix.mem_wren),  32'(tbl[i].we));
            chk($sformatf("tbl%0d mem_waddr", i), 32'(if_fix.mem_waddr), 32'(tbl[i].wa));
            chk($sformatf("tbl%0d mem_wdata", i), 32'(if_fix.mem_wdata), 32'(tbl[i].wd));
        end
        idle_inputs();
        step(); step(); step();

        // Starvation: client 1 wins 15 times, then client 0 gets one grant
        if_fix.rd_addr = {19'h12C00, 19'h00100};
        if_fix.rd_req  = 2'b11;
        for (int k = 0; k < 32; k++) begin
            step();
            chk($sformatf("starve%0d rd_gnt", k), 32'(if_fix.rd_gnt),
                (k % 16 == 15) ? 32'h1 : 32'h2);
            chk($sformatf("starve%0d mem_raddr", k), 32'(if_fix.mem_raddr),
                (k % 16 == 15) ? 32'h00100 : 32'h12C00);
        end
        if_fix.rd_req = 2'b00;
        step(); step(); step();

        // Back-to-back reads 0,1,0 at addresses 1,2,3
        for (int k = 0; k < 6; k++) begin
            if_fix.rd_req = 2'b00;
            if (k == 0) begin if_fix.rd_req = 2'b01; if_fix.rd_addr = {19'h0, 19'h1}; end
            if (k == 1) begin if_fix.rd_req = 2'b10; if_fix.rd_addr = {19'h2, 19'h0}; end
            if (k == 2) begin if_fix.rd_req = 2'b01; if_fix.rd_addr = {19'h0, 19'h3}; end
            step();
            chk($sformatf("b2b%0d rd_gnt", k),   32'(if_fix.rd_gnt),   32'(b2b_gnt[k]));
            chk($sformatf("b2b%0d rd_valid", k), 32'(if_fix.rd_valid), 32'(b2b_vld[k]));
            if (k >= 2 && k <= 4)
                chk($sformatf("b2b%0d rd_data", k), 32'(if_fix.rd_data), 32'(b2b_dat[k]));
        end

        // Reset while a read is in flight
        if_fix.rd_req  = 2'b01;
        if_fix.rd_addr = {19'h0, 19'h00010};
        step();
        chk("midrst rd_gnt", 32'(if_fix.rd_gnt), 32'h1);
        idle_inputs();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("midrst rd_gnt0",    32'(if_fix.rd_gnt),    32'h0);
            chk("midrst rd_valid0",  32'(if_fix.rd_valid),  32'h0);
            chk("midrst rd_data0",   32'(if_fix.rd_data),   32'h0);
            chk("midrst mem_raddr0", 32'(if_fix.mem_raddr), 32'h0);
            chk("midrst mem_wren0",  32'(if_fix.mem_wren),  32'h0);
            chk("midrst mem_waddr0", 32'(if_fix.mem_waddr), 32'h0);
            chk("midrst mem_wdata0", 32'(if_fix.mem_wdata), 32'h0);
        end
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst no rd_valid", 32'(if_fix.rd_valid), 32'h0);
        end

        // Round-robin, all four requesting
        for (int i = 0; i < 4; i++) if_rr.rd_addr[i*19 +: 19] = 19'(i * 32'h1000 + 32'h10);
        if_rr.rd_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk($sformatf("rr_all%0d rd_gnt", k),    32'(if_rr.rd_gnt),    32'(1 << (k % 4)));
            chk($sformatf("rr_all%0d mem_raddr", k), 32'(if_rr.mem_raddr), 32'((k % 4) * 32'h1000 + 32'h10));
        end
        // Only clients 1 and 3
        if_rr.rd_req = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rr_13_%0d rd_gnt", k),    32'(if_rr.rd_gnt),    (k % 2 == 0) ? 32'h2 : 32'h8);
            chk($sformatf("rr_13_%0d mem_raddr", k), 32'(if_rr.mem_raddr), (k % 2 == 0) ? 32'h1010 : 32'h3010);
        end
        if_rr.rd_req = 4'b0000;

        // RAM_LAT=2: valid appears three cycles after the grant
        if_lat.rd_req  = 2'b01;
        if_lat.rd_addr = {19'h0, 19'h00042};
        step();
        chk("lat rd_gnt t",    32'(if_lat.rd_gnt),    32'h1);
        chk("lat mem_raddr t", 32'(if_lat.mem_raddr), 32'h42);
        if_lat.rd_req = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step();
            chk($sformatf("lat t+%0d rd_valid", k), 32'(if_lat.rd_valid), (k == 3) ? 32'h1 : 32'h0);
            if (k == 3) chk("lat t+3 rd_data", 32'(if_lat.rd_data), 32'hA5);
        end
        chk("lat rd_gnt after", 32'(if_lat.rd_gnt), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mm_arbiter.md
Name: mm_arbiter

Overview:
- Parametrised main-memory front end; successor to the two-reader fixed-mux memory manager.
- Arbitrates NUM_RD read clients (CPU, VGA, DMA, ...) onto the single read port of the main-memory RAM, with registered address, request/grant handshake and per-client read-valid tracking over a configurable RAM latency.
- Write port is registered and passed straight through to the RAM's independent write port.
- Sits between the CPU/VGA/peripheral masters and the MMemory RAM instance.

Parameters:
- DATA_W, 8: data width.
- ADDR_W, 19: address width.
- NUM_RD, 2: number of read clients; must be at least 2.
- RAM_LAT, 1: cycles from mem_raddr registered to mem_rdata valid; must be at least 1.
- RR_MODE, 0: 0 = fixed priority, highest index wins (VGA on top); 1 = round-robin.
- MAX_WAIT, 15: fixed-priority anti-starvation limit, in cycles; 0 disables it.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- rd_req  in  NUM_RD  per-client read request; hold with address until granted.
- rd_addr  in  NUM_RD*ADDR_W  client i address in bits [i*ADDR_W +: ADDR_W].
- rd_gnt  out  NUM_RD  one-hot pulse; request accepted.
- rd_valid  out  NUM_RD  one-hot pulse; rd_data belongs to this client.
- rd_data  out  DATA_W  shared read data.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- mem_raddr  out  ADDR_W  registered RAM read address.
- mem_wren  out  1  registered RAM write enable.
- mem_waddr  out  ADDR_W  registered RAM write address.
- mem_wdata  out  DATA_W  registered RAM write data.
- mem_rdata  in  DATA_W  RAM read data.

Behaviour:
- Reset values: rd_gnt=0, rd_valid=0, rd_data=0, mem_raddr=0, mem_wren=0, mem_waddr=0, mem_wdata=0, RR pointer=NUM_RD-1 (client 0 first), all wait counters=0, valid pipeline cleared.
- Reset mid-operation: in-flight reads are dropped and never produce rd_valid.
- Arbitration:
  - Each cycle, if any rd_req is high, exactly one client w is selected.
  - At the clock edge: mem_raddr <= addr[w], rd_gnt <= onehot(w).
  - One grant per cycle max; back-to-back grants are allowed, giving full throughput.
- Client handshake:
  - Client keeps rd_req and rd_addr stable until it sees rd_gnt[i]=1.
  - It may drop or re-issue the request in the cycle after the grant.
  - A request held through a grant cycle counts as a new request.
- Fixed mode (RR_MODE=0):
  - Highest-index requester wins.
  - Each requesting, non-granted client increments a saturating wait counter; the counter clears on grant or when the request is low.
  - When a counter reaches MAX_WAIT, that client overrides priority on the next selection.
  - If several clients are starved, the highest index among them wins.
- Round-robin mode (RR_MODE=1):
  - Search starts at pointer+1 modulo NUM_RD; the first requester wins.
  - Pointer updates to w only on a grant.
  - Wait counters are unused.
- Read return:
  - A shift pipeline of depth RAM_LAT carries the one-hot tag of each grant.
  - rd_valid = tag at depth RAM_LAT and rd_data = mem_rdata, registered.
  - rd_valid[i] therefore rises exactly RAM_LAT+1 cycles after rd_gnt[i].
  - Return order equals grant order.
- Write path:
  - mem_wren/mem_waddr/mem_wdata <= wr_en/wr_addr/wr_data every cycle, 1-cycle latency.
  - Writes are never stalled and do not interact with read arbitration.
  - No read-after-write forwarding; same-address collision result is defined by the RAM.
- Single requester: granted in the cycle after rd_req rises, in either mode.

Test Plan:
- Reset mid-read: grant client 0 at addr 0x00010, assert rst before rd_valid -> no rd_valid ever appears; all outputs read 0 after reset.
- Fixed mode, NUM_RD=2, RAM_LAT=1: both request continuously, client 1 at 0x12C00, client 0 at 0x00100 -> rd_gnt=2'b10 every cycle until client 0 waits 15 cycles, then one 2'b01 grant; mem_raddr follows.
- Round-robin mode, NUM_RD=4, all requesting -> grant order 0,1,2,3,0,...; with only clients 1 and 3 requesting -> 1,3,1,3.
- Latency, RAM_LAT=2, memory model preloaded with 0xA5 at 0x00042: client 0 requests 0x00042 -> rd_gnt[0] at cycle t, rd_valid[0] with rd_data=0xA5 at t+3, no other valid.
- Back-to-back reads from clients 0,1,0 at addresses 1,2,3 with data 0x11,0x22,0x33 -> rd_valid pulses on consecutive cycles, correct tags and data, in grant order.
- Concurrent write: wr_en to 0x00005 with 0x7E while read arbitration is active -> mem_wren/mem_waddr/mem_wdata asserted one cycle later; read grants unaffected.
